// File: rtl/cpu_types_pkg.sv
// Types and constants shared by the iterative divider and its bus interface.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    WB
  } div_state_t;

  localparam int DIV_ITER = 32;

  function automatic word_t abs_w(input word_t x, input logic sgn);
    return (sgn && x[31]) ? word_t'(-x) : x;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request and register-file write signals of the divider.
interface div_unit_if;

  logic                    start;
  logic                    op_signed;
  logic                    op_rem;
  cpu_types_pkg::word_t    dividend;
  cpu_types_pkg::word_t    divisor;
  cpu_types_pkg::regbits_t dest;
  logic                    flush;
  logic                    wb_ready;
  logic                    busy;
  logic                    WEN;
  cpu_types_pkg::regbits_t wsel;
  cpu_types_pkg::word_t    wdat;
  logic                    done;

  modport master (
    output start, op_signed, op_rem, dividend, divisor, dest, flush, wb_ready,
    input  busy, WEN, wsel, wdat, done
  );

  modport slave (
    input  start, op_signed, op_rem, dividend, divisor, dest, flush, wb_ready,
    output busy, WEN, wsel, wdat, done
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift/subtract iteration: the dividend bits shift out of the
// top of quo_i while quotient bits shift into its bottom.
module div_step
  import cpu_types_pkg::*;
(
  input  word_t rem_i,
  input  word_t quo_i,
  input  word_t dvs_i,
  output word_t rem_o,
  output word_t quo_o
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        qbit;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, dvs_i};
    qbit    = ~diff[32];
    rem_o   = qbit ? diff[31:0] : shifted[31:0];
    quo_o   = {quo_i[30:0], qbit};
  end

endmodule

// File: rtl/div_unit.sv
// 32-cycle restoring divider with sign fix-up and register-file writeback.
// Define DIV_EARLY_OUT_EN to skip iteration when divisor==0 or |dividend|<|divisor|.
module div_unit
  import cpu_types_pkg::*;
(
  input logic       CLK,
  input logic       nRST,
  div_unit_if.slave bus
);

  div_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  word_t      rem_q, rem_d;
  word_t      quo_q, quo_d;
  word_t      dvs_q, dvs_d;
  word_t      res_q, res_d;
  regbits_t   dest_q, dest_d;
  logic       op_rem_q, op_rem_d;
  logic       q_neg_q, q_neg_d;
  logic       r_neg_q, r_neg_d;

  word_t      abs_dvd, abs_dvs;
  word_t      step_rem, step_quo;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    dest_d   = dest_q;
    op_rem_d = op_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    bus.busy = (state_q != IDLE);
    bus.WEN  = 1'b0;
    bus.wsel = '0;
    bus.wdat = '0;
    bus.done = 1'b0;

    abs_dvd = abs_w(bus.dividend, bus.op_signed);
    abs_dvs = abs_w(bus.divisor, bus.op_signed);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d    = '0;
          quo_d    = abs_dvd;
          dvs_d    = abs_dvs;
          cnt_d    = '0;
          dest_d   = bus.dest;
          op_rem_d = bus.op_rem;
          // Divide-by-zero keeps the all-ones quotient unsigned regardless of signs.
          q_neg_d  = bus.op_signed && (bus.dividend[31] ^ bus.divisor[31]) &&
                     (bus.divisor != '0);
          r_neg_d  = bus.op_signed && bus.dividend[31];
          state_d  = CALC;
`ifdef DIV_EARLY_OUT_EN
          if ((bus.divisor == '0) || (abs_dvd < abs_dvs)) begin
            res_d   = bus.op_rem ? bus.dividend : ((bus.divisor == '0) ? '1 : '0);
            state_d = WB;
          end
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITER - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (op_rem_q) begin
          res_d = r_neg_q ? word_t'(-rem_q) : rem_q;
        end else begin
          res_d = q_neg_q ? word_t'(-quo_q) : quo_q;
        end
        state_d = WB;
      end
      WB: begin
        bus.wsel = dest_q;
        bus.wdat = res_q;
        bus.WEN  = (dest_q != '0) && !bus.flush;
        if (!bus.flush && ((dest_q == '0) || bus.wb_ready)) begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      dest_q   <= '0;
      op_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      dest_q   <= dest_d;
      op_rem_q <= op_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected writebacks queued at issue,
// popped and compared when the unit presents its write request.
module tb_div_unit;
  import cpu_types_pkg::*;

  typedef struct {
    regbits_t wsel;
    word_t    wdat;
    logic     wen;
    int       lat;
  } exp_t;

  typedef struct {
    logic     sgn;
    logic     rem;
    word_t    a;
    word_t    b;
    regbits_t d;
    word_t    q;
  } vec_t;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  div_unit_if bus();

  div_unit dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic word_t model(input logic sgn, input logic rem, input word_t a, input word_t b);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
      return rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return rem ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic sgn, input word_t a, input word_t b);
    word_t aa, bb;
    logic  early_ok;
    aa = (sgn && a[31]) ? -a : a;
    bb = (sgn && b[31]) ? -b : b;
    early_ok = (b == 32'd0) || (aa < bb);
    return (EARLY && early_ok) ? 1 : 34;
  endfunction

  // Drives one accept edge, queues the expectation, then scrambles the operands.
  task automatic issue(input logic sgn, input logic rem, input word_t a, input word_t b,
                       input regbits_t d, input word_t expv);
    exp_t e;
    e.wsel = d;
    e.wdat = expv;
    e.wen  = (d != 5'd0);
    e.lat  = exp_lat(sgn, a, b);
    sb.push_back(e);
    bus.start     = 1'b1;
    bus.op_signed = sgn;
    bus.op_rem    = rem;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.dest      = d;
    tick();
    bus.start     = 1'b0;
    bus.op_signed = 1'($urandom);
    bus.op_rem    = 1'($urandom);
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    bus.dest      = 5'($urandom);
  endtask

  // lat=1 is the cycle right after the accept edge.
  task automatic wait_wb(output int lat, output bit tmo);
    lat = 1;
    tmo = 1'b0;
    while (!(bus.WEN || bus.done)) begin
      if (lat >= 100) begin
        tmo = 1'b1;
        return;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.WEN !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.WEN); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.wsel !== 5'd0) begin failures++; $display("FAIL reset_wsel got=%0d exp=0", bus.wsel); end
    checks++; if (bus.wdat !== 32'd0) begin failures++; $display("FAIL reset_wdat got=%h exp=0", bus.wdat); end
    nRST = 1'b0;
    tick();
  endtask

  task automatic test_ops();
    vec_t     v [16];
    exp_t     e;
    int       lat;
    bit       tmo;
    logic     sgn, rem;
    word_t    a, b, q;
    regbits_t d;
    v = '{
      '{1'b0, 1'b0, 32'd100,        32'd7,          5'd5,  32'd14},
      '{1'b0, 1'b1, 32'd100,        32'd7,          5'd5,  32'd2},
      '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD},
      '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF},
      '{1'b0, 1'b0, 32'd9,          32'd0,          5'd8,  32'hFFFF_FFFF},
      '{1'b0, 1'b1, 32'd9,          32'd0,          5'd8,  32'd9},
      '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000},
      '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h0},
      '{1'b1, 1'b0, 32'hFFFF_FFF7,  32'd0,          5'd10, 32'hFFFF_FFFF},
      '{1'b1, 1'b1, 32'hFFFF_FFF7,  32'd0,          5'd10, 32'hFFFF_FFF7},
      '{1'b0, 1'b0, 32'd3,          32'd10,         5'd11, 32'd0},
      '{1'b0, 1'b1, 32'd3,          32'd10,         5'd11, 32'd3},
      '{1'b1, 1'b0, 32'd100,        32'hFFFF_FFF9,  5'd12, 32'hFFFF_FFF2},
      '{1'b1, 1'b1, 32'd100,        32'hFFFF_FFF9,  5'd12, 32'd2},
      '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF},
      '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd10,         5'd31, 32'd5}
    };
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i < 16) begin
        sgn = v[i].sgn; rem = v[i].rem; a = v[i].a; b = v[i].b; d = v[i].d; q = v[i].q;
      end else begin
        sgn = 1'($urandom);
        rem = 1'($urandom);
        a   = (i % 3 == 0) ? 32'($urandom_range(0, 50)) : $urandom;
        b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
        if (b == 32'd0) b = 32'd1;
        d   = 5'($urandom_range(1, 31));
        q   = model(sgn, rem, a, b);
      end
      issue(sgn, rem, a, b, d, q);
      wait_wb(lat, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || lat != e.lat) begin
        failures++;
        $display("FAIL ops%0d_latency got=%0d exp=%0d timeout=%0d", i, lat, e.lat, tmo);
      end
      checks++;
      if (bus.WEN !== e.wen || bus.wsel !== e.wsel || bus.wdat !== e.wdat || bus.done !== 1'b1) begin
        failures++;
        $display("FAIL ops%0d_write got WEN=%b wsel=%0d wdat=%h done=%b exp WEN=%b wsel=%0d wdat=%h done=1",
                 i, bus.WEN, bus.wsel, bus.wdat, bus.done, e.wen, e.wsel, e.wdat);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL ops%0d_retire got busy=%b done=%b exp busy=0 done=0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_wb_stall();
    exp_t e;
    int   lat;
    bit   tmo;
    bus.wb_ready = 1'b0;
    issue(1'b0, 1'b0, 32'd1000, 32'd3, 5'd7, 32'd333);
    wait_wb(lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat != e.lat) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", lat, e.lat); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.WEN !== 1'b1 || bus.wsel !== e.wsel || bus.wdat !== e.wdat || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got WEN=%b wsel=%0d wdat=%h done=%b exp WEN=1 wsel=%0d wdat=%h done=0",
                 k, bus.WEN, bus.wsel, bus.wdat, bus.done, e.wsel, e.wdat);
      end
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.WEN !== 1'b1 || bus.wdat !== e.wdat) begin
      failures++;
      $display("FAIL stall_grant got done=%b WEN=%b wdat=%h exp done=1 WEN=1 wdat=%h", bus.done, bus.WEN, bus.wdat, e.wdat);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.WEN !== 1'b0) begin
      failures++;
      $display("FAIL stall_after got done=%b busy=%b WEN=%b exp all 0", bus.done, bus.busy, bus.WEN);
    end
  endtask

  task automatic test_dest0();
    exp_t e;
    int   lat;
    bit   tmo;
    bus.wb_ready = 1'b0;
    issue(1'b0, 1'b0, 32'd20, 32'd4, 5'd0, 32'd5);
    wait_wb(lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat != e.lat) begin failures++; $display("FAIL dest0_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (bus.WEN !== 1'b0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL dest0_pulse got WEN=%b done=%b exp WEN=0 done=1", bus.WEN, bus.done);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.WEN !== 1'b0) begin
      failures++;
      $display("FAIL dest0_after got busy=%b done=%b WEN=%b exp all 0", bus.busy, bus.done, bus.WEN);
    end
    bus.wb_ready = 1'b1;
  endtask

  task automatic test_flush();
    exp_t e;
    int   lat;
    bit   tmo;
    bit   seen;
    bus.wb_ready = 1'b1;
    issue(1'b0, 1'b0, 32'd50, 32'd5, 5'd3, 32'd10);
    e = sb.pop_front();
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.WEN !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc got busy=%b WEN=%b done=%b exp all 0", bus.busy, bus.WEN, bus.done);
    end
    seen = 1'b0;
    repeat (40) begin
      if (bus.WEN || bus.done) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin failures++; $display("FAIL flush_quiet got write_or_done=1 exp 0"); end
    issue(1'b1, 1'b0, 32'hFFFF_FFCE, 32'd5, 5'd4, 32'hFFFF_FFF6);
    wait_wb(lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat != e.lat || bus.WEN !== 1'b1 || bus.wsel !== e.wsel || bus.wdat !== e.wdat) begin
      failures++;
      $display("FAIL flush_restart got lat=%0d WEN=%b wsel=%0d wdat=%h exp lat=%0d WEN=1 wsel=%0d wdat=%h",
               lat, bus.WEN, bus.wsel, bus.wdat, e.lat, e.wsel, e.wdat);
    end
    tick();
    bus.wb_ready = 1'b0;
    issue(1'b0, 1'b1, 32'd50, 32'd7, 5'd2, 32'd1);
    wait_wb(lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat != e.lat || bus.wdat !== e.wdat) begin
      failures++;
      $display("FAIL flushwb_reach got lat=%0d wdat=%h exp lat=%0d wdat=%h", lat, bus.wdat, e.lat, e.wdat);
    end
    bus.flush    = 1'b1;
    bus.wb_ready = 1'b1;
    bus.start    = 1'b1;
    #1;
    checks++;
    if (bus.WEN !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL flushwb_prio got WEN=%b done=%b exp WEN=0 done=0", bus.WEN, bus.done);
    end
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.WEN !== 1'b0) begin
      failures++;
      $display("FAIL flushwb_after got busy=%b done=%b WEN=%b exp all 0", bus.busy, bus.done, bus.WEN);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    bus.wb_ready = 1'b1;
    issue(1'b0, 1'b0, 32'd77, 32'd7, 5'd9, 32'd11);
    e = sb.pop_front();
    repeat (5) tick();
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.WEN !== 1'b0 || bus.done !== 1'b0 || bus.wsel !== 5'd0 || bus.wdat !== 32'd0) begin
      failures++;
      $display("FAIL midreset_outs got busy=%b WEN=%b done=%b wsel=%0d wdat=%h exp all 0",
               bus.busy, bus.WEN, bus.done, bus.wsel, bus.wdat);
    end
    seen = 1'b0;
    repeat (40) begin
      if (bus.WEN || bus.done || bus.busy) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midreset_quiet got activity=1 exp 0"); end
  endtask

  task automatic test_back_to_back();
    exp_t e, e2;
    int   lat;
    bit   tmo;
    bus.wb_ready = 1'b1;
    issue(1'b0, 1'b0, 32'd200, 32'd9, 5'd13, 32'd22);
    bus.start     = 1'b1;
    bus.op_signed = 1'b0;
    bus.op_rem    = 1'b0;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'd7;
    bus.dest      = 5'd14;
    wait_wb(lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat != e.lat || bus.wsel !== e.wsel || bus.wdat !== e.wdat || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d wsel=%0d wdat=%h done=%b exp lat=%0d wsel=%0d wdat=%h done=1",
               lat, bus.wsel, bus.wdat, bus.done, e.lat, e.wsel, e.wdat);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_retire_start got busy=%b exp 0", bus.busy); end
    e2 = '{wsel: 5'd14, wdat: 32'd11, wen: 1'b1, lat: exp_lat(1'b0, 32'd77, 32'd7)};
    sb.push_back(e2);
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 && e2.lat != 1) begin failures++; $display("FAIL b2b_accept got busy=%b exp 1", bus.busy); end
    wait_wb(lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat != e.lat || bus.WEN !== 1'b1 || bus.wsel !== e.wsel || bus.wdat !== e.wdat) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d WEN=%b wsel=%0d wdat=%h exp lat=%0d WEN=1 wsel=%0d wdat=%h",
               lat, bus.WEN, bus.wsel, bus.wdat, e.lat, e.wsel, e.wdat);
    end
    tick();
  endtask

  initial begin
    nRST          = 1'b1;
    bus.start     = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_rem    = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.dest      = '0;
    bus.flush     = 1'b0;
    bus.wb_ready  = 1'b1;
    test_reset();
    test_ops();
    test_wb_stall();
    test_dest0();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
